main_control_fsm: RTL and testbench



---
 rtl/main_control_fsm.sv | 211 +++++++++++++++++++++
 tb/tb_main_control_fsm.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/main_control_fsm.sv
// Multi-cycle main control unit for the RISC_16 datapath.
// Steps each instruction through fetch, decode, execute, memory and writeback.
// Drives the datapath enables and the 2-bit ALUOp for the ALU control decoder.
// Also counts retired instructions and flags illegal opcodes and halt.
module main_control_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       opcode,
  input  logic             mem_ready,
  output logic [1:0]       alu_op,
  output logic             alu_src,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             branch_eq,
  output logic             branch_ne,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             illegal_op,
  output logic             halted,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_WB_R   = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_WB_LD  = 4'd7,
    S_MEM_WR = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_HALT   = 4'd11
  } state_e;

  localparam logic [3:0] OP_LD   = 4'h0;
  localparam logic [3:0] OP_ST   = 4'h1;
  localparam logic [3:0] OP_BEQ  = 4'hB;
  localparam logic [3:0] OP_BNE  = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ALU_RTYPE = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_ADD   = 2'b10;

  localparam logic [1:0] PC_PLUS2  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;

  // State, latched opcode and retire counter; reset aborts any instruction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      retired_q <= retired_d;
    end
  end

  // Next-state and Moore outputs; only FETCH's pc_write/ir_write depend on mem_ready
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    retire     = 1'b0;
    alu_op     = ALU_RTYPE;
    alu_src    = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_PLUS2;
    branch_eq  = 1'b0;
    branch_ne  = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal_op = 1'b0;
    halted     = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        mem_read = 1'b1;
        alu_op   = ALU_ADD;
        if (mem_ready) begin
          pc_write = 1'b1;
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        alu_op = ALU_ADD;
        op_d   = opcode;
        case (opcode)
          OP_LD, OP_ST:                         state_d = S_ADDR;
          4'h2, 4'h3, 4'h4, 4'h5,
          4'h6, 4'h7, 4'h8, 4'h9:               state_d = S_EXEC_R;
          OP_BEQ, OP_BNE:                       state_d = S_BRANCH;
          OP_JMP:                               state_d = S_JUMP;
          OP_HALT: begin
            state_d = S_HALT;
            retire  = 1'b1;
          end
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end

      S_EXEC_R: begin
        alu_op  = ALU_RTYPE;
        state_d = S_WB_R;
      end

      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end

      S_ADDR: begin
        alu_op  = ALU_ADD;
        alu_src = 1'b1;
        state_d = (op_q == OP_LD) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          state_d = S_WB_LD;
        end
      end

      S_WB_LD: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_BRANCH: begin
        alu_op    = ALU_SUB;
        pc_src    = PC_BRANCH;
        branch_eq = (op_q == OP_BEQ);
        branch_ne = (op_q == OP_BNE);
        retire    = 1'b1;
        state_d   = S_FETCH;
      end

      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PC_JUMP;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Retire counter increments as a terminal state is left and wraps naturally
  always_comb begin
    retired_d = retire ? (retired_q + CNT_W'(1)) : retired_q;
  end

  assign retired   = retired_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed testbench for main_control_fsm with hand-computed expectations.
// Runs with a 4-bit retire counter so wrap-around is reachable quickly.
module tb_main_control_fsm;

  localparam int CNT_W = 4;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_EXEC_R = 4'd3;
  localparam logic [3:0] S_WB_R   = 4'd4;
  localparam logic [3:0] S_ADDR   = 4'd5;
  localparam logic [3:0] S_MEM_RD = 4'd6;
  localparam logic [3:0] S_WB_LD  = 4'd7;
  localparam logic [3:0] S_MEM_WR = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;
  localparam logic [3:0] S_HALT   = 4'd11;

  // Control bundle layout:
  // [17:16] alu_op [15] alu_src [14] pc_write [13:12] pc_src [11] branch_eq
  // [10] branch_ne [9] ir_write [8] mem_read [7] mem_write [6] i_or_d
  // [5] reg_write [4] reg_dst [3] mem_to_reg [2] illegal_op [1] halted [0] zero
  localparam logic [17:0] A_ADD   = 18'h20000;
  localparam logic [17:0] A_SUB   = 18'h10000;
  localparam logic [17:0] ASRC    = 18'h08000;
  localparam logic [17:0] PCW     = 18'h04000;
  localparam logic [17:0] PCS_BR  = 18'h01000;
  localparam logic [17:0] PCS_J   = 18'h02000;
  localparam logic [17:0] BEQ     = 18'h00800;
  localparam logic [17:0] BNE     = 18'h00400;
  localparam logic [17:0] IRW     = 18'h00200;
  localparam logic [17:0] MRD     = 18'h00100;
  localparam logic [17:0] MWR     = 18'h00080;
  localparam logic [17:0] IOD     = 18'h00040;
  localparam logic [17:0] RW      = 18'h00020;
  localparam logic [17:0] RDST    = 18'h00010;
  localparam logic [17:0] M2R     = 18'h00008;
  localparam logic [17:0] ILL     = 18'h00004;
  localparam logic [17:0] HLT     = 18'h00002;

  localparam logic [17:0] E_IDLE       = 18'h0;
  localparam logic [17:0] E_FETCH_WAIT = A_ADD | MRD;
  localparam logic [17:0] E_FETCH_GO   = A_ADD | MRD | PCW | IRW;
  localparam logic [17:0] E_DECODE     = A_ADD;
  localparam logic [17:0] E_DECODE_ILL = A_ADD | ILL;
  localparam logic [17:0] E_EXEC_R     = 18'h0;
  localparam logic [17:0] E_WB_R       = RW | RDST;
  localparam logic [17:0] E_ADDR       = A_ADD | ASRC;
  localparam logic [17:0] E_MEM_RD     = MRD | IOD;
  localparam logic [17:0] E_WB_LD      = RW | M2R;
  localparam logic [17:0] E_MEM_WR     = MWR | IOD;
  localparam logic [17:0] E_BEQ        = A_SUB | PCS_BR | BEQ;
  localparam logic [17:0] E_BNE        = A_SUB | PCS_BR | BNE;
  localparam logic [17:0] E_JUMP       = PCW | PCS_J;
  localparam logic [17:0] E_HALT       = HLT;

  logic             clk;
  logic             rst;
  logic [3:0]       opcode;
  logic             mem_ready;
  logic [1:0]       alu_op;
  logic             alu_src;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             branch_eq;
  logic             branch_ne;
  logic             ir_write;
  logic             mem_read;
  logic             mem_write;
  logic             i_or_d;
  logic             reg_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             illegal_op;
  logic             halted;
  logic [CNT_W-1:0] retired;
  logic [3:0]       state_dbg;
  logic [17:0]      ctl_obs;

  int checks = 0;
  int passes = 0;

  main_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .alu_op     (alu_op),
    .alu_src    (alu_src),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .branch_eq  (branch_eq),
    .branch_ne  (branch_ne),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .i_or_d     (i_or_d),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .illegal_op (illegal_op),
    .halted     (halted),
    .retired    (retired),
    .state_dbg  (state_dbg)
  );

  assign ctl_obs = {alu_op, alu_src, pc_write, pc_src, branch_eq, branch_ne,
                    ir_write, mem_read, mem_write, i_or_d, reg_write, reg_dst,
                    mem_to_reg, illegal_op, halted, 1'b0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input int unsigned actual,
                             input int unsigned expected);
    checks++;
    if (actual == expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, check state and control bundle, then advance
  task automatic applyStimulus(input string tag, input logic ready,
                               input logic [3:0] opc, input logic [3:0] exp_state,
                               input logic [17:0] exp_ctl);
    mem_ready = ready;
    opcode    = opc;
    #1;
    checkOutput({tag, "_state"}, state_dbg, exp_state);
    checkOutput({tag, "_ctl"}, ctl_obs, exp_ctl);
    tick();
  endtask

  task automatic runJmp(input string tag);
    applyStimulus({tag, "_fetch"}, 1'b1, 4'hD, S_FETCH, E_FETCH_GO);
    applyStimulus({tag, "_decode"}, 1'b1, 4'hD, S_DECODE, E_DECODE);
    applyStimulus({tag, "_jump"}, 1'b1, 4'hD, S_JUMP, E_JUMP);
  endtask

  initial begin
    rst       = 1'b1;
    opcode    = 4'h0;
    mem_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    #1;
    checkOutput("rst_retired", retired, 0);
    applyStimulus("rst_idle", 1'b1, 4'h4, S_IDLE, E_IDLE);

    // R-type: 4 cycles, retired 0 -> 1
    applyStimulus("r_fetch", 1'b1, 4'h4, S_FETCH, E_FETCH_GO);
    applyStimulus("r_decode", 1'b1, 4'h4, S_DECODE, E_DECODE);
    applyStimulus("r_exec", 1'b1, 4'h4, S_EXEC_R, E_EXEC_R);
    checkOutput("r_retired_before", retired, 0);
    applyStimulus("r_wb", 1'b1, 4'h4, S_WB_R, E_WB_R);
    checkOutput("r_retired_after", retired, 1);

    // LD with three wait cycles in MEM_RD: 8 cycles total
    applyStimulus("ld_fetch", 1'b1, 4'h0, S_FETCH, E_FETCH_GO);
    applyStimulus("ld_decode", 1'b1, 4'h0, S_DECODE, E_DECODE);
    applyStimulus("ld_addr", 1'b1, 4'h0, S_ADDR, E_ADDR);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("ld_memrd_wait", 1'b0, 4'h0, S_MEM_RD, E_MEM_RD);
    end
    applyStimulus("ld_memrd_go", 1'b1, 4'h0, S_MEM_RD, E_MEM_RD);
    applyStimulus("ld_wb", 1'b1, 4'h0, S_WB_LD, E_WB_LD);
    checkOutput("ld_retired", retired, 2);

    // ST with no wait: 4 cycles
    applyStimulus("st_fetch", 1'b1, 4'h1, S_FETCH, E_FETCH_GO);
    applyStimulus("st_decode", 1'b1, 4'h1, S_DECODE, E_DECODE);
    applyStimulus("st_addr", 1'b1, 4'h1, S_ADDR, E_ADDR);
    applyStimulus("st_memwr", 1'b1, 4'h1, S_MEM_WR, E_MEM_WR);
    checkOutput("st_retired", retired, 3);

    // BEQ then BNE
    applyStimulus("beq_fetch", 1'b1, 4'hB, S_FETCH, E_FETCH_GO);
    applyStimulus("beq_decode", 1'b1, 4'hB, S_DECODE, E_DECODE);
    applyStimulus("beq_branch", 1'b1, 4'hB, S_BRANCH, E_BEQ);
    applyStimulus("bne_fetch", 1'b1, 4'hC, S_FETCH, E_FETCH_GO);
    applyStimulus("bne_decode", 1'b1, 4'hC, S_DECODE, E_DECODE);
    applyStimulus("bne_branch", 1'b1, 4'hC, S_BRANCH, E_BNE);
    checkOutput("br_retired", retired, 5);

    // Illegal opcode: 2 cycles, no retire
    applyStimulus("ill_fetch", 1'b1, 4'hA, S_FETCH, E_FETCH_GO);
    applyStimulus("ill_decode", 1'b1, 4'hA, S_DECODE, E_DECODE_ILL);
    checkOutput("ill_retired", retired, 5);
    applyStimulus("ill2_fetch", 1'b1, 4'hE, S_FETCH, E_FETCH_GO);
    applyStimulus("ill2_decode", 1'b1, 4'hE, S_DECODE, E_DECODE_ILL);
    checkOutput("ill2_retired", retired, 5);

    // FETCH stalled five cycles, then a JMP
    for (int i = 0; i < 5; i++) begin
      applyStimulus("stall_fetch", 1'b0, 4'hD, S_FETCH, E_FETCH_WAIT);
    end
    applyStimulus("stall_decode_pre", 1'b1, 4'hD, S_FETCH, E_FETCH_GO);
    applyStimulus("stall_decode", 1'b1, 4'hD, S_DECODE, E_DECODE);
    applyStimulus("stall_jump", 1'b1, 4'hD, S_JUMP, E_JUMP);
    checkOutput("stall_retired", retired, 6);

    // Nine more JMPs reach 15, the tenth wraps to 0, one more gives 1
    for (int i = 0; i < 9; i++) begin
      runJmp("jmp");
    end
    checkOutput("wrap_at_max", retired, 15);
    runJmp("jmp_wrap");
    checkOutput("wrap_to_zero", retired, 0);
    runJmp("jmp_post");
    checkOutput("post_wrap", retired, 1);

    // ST aborted by reset while waiting in MEM_WR
    applyStimulus("abort_fetch", 1'b1, 4'h1, S_FETCH, E_FETCH_GO);
    applyStimulus("abort_decode", 1'b1, 4'h1, S_DECODE, E_DECODE);
    applyStimulus("abort_addr", 1'b1, 4'h1, S_ADDR, E_ADDR);
    applyStimulus("abort_memwr", 1'b0, 4'h1, S_MEM_WR, E_MEM_WR);
    rst = 1'b1;
    #1;
    checkOutput("abort_memwr_held", mem_write, 1);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("abort_memwr_drop", mem_write, 0);
    checkOutput("abort_retired", retired, 0);
    applyStimulus("abort_idle", 1'b0, 4'h1, S_IDLE, E_IDLE);

    // HALT: retire once on entry, then parked with only halted asserted
    applyStimulus("halt_fetch", 1'b1, 4'hF, S_FETCH, E_FETCH_GO);
    applyStimulus("halt_decode", 1'b1, 4'hF, S_DECODE, E_DECODE);
    for (int i = 0; i < 20; i++) begin
      applyStimulus("halt_hold", i[0], 4'h2, S_HALT, E_HALT);
    end
    checkOutput("halt_retired", retired, 1);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
